// File: rtl/mux_nto1_pipe.sv
// mux_nto1_pipe: N-input, WIDTH-bit selector with a registered output stage,
// valid/ready handshakes on both sides and a 2-entry skid buffer (output
// register + one skid entry) for full throughput under backpressure.
// Optional feature macro: MUX_SEL_ERR_CNT_EN adds a saturating 8-bit err_cnt
// output counting transferred beats that came from an out-of-range select.
module mux_nto1_pipe #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      NUM_IN      = 3,
    parameter int unsigned      SEL_W       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
`ifdef MUX_SEL_ERR_CNT_EN
    ,
    output logic [7:0]              err_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             sel_err_q, sel_err_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_err_q, skid_err_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic [WIDTH-1:0] sel_word_c;
    logic             sel_hit_c;
    logic             accept_c;
    logic             xfer_c;

    // Select the addressed input; unused codes fall back to DEFAULT_VAL
    always_comb begin
        sel_word_c = DEFAULT_VAL;
        sel_hit_c  = 1'b0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_word_c = in_data[i*WIDTH +: WIDTH];
                sel_hit_c  = 1'b1;
            end
        end
    end

    assign accept_c = in_valid & in_ready_q;
    assign xfer_c   = out_valid_q & out_ready;

    // Next-state and datapath: output register plus one skid entry
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        sel_err_d   = sel_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;

        case (state_q)
            EMPTY: begin
                if (accept_c) begin
                    out_data_d = sel_word_c;
                    sel_err_d  = ~sel_hit_c;
                    state_d    = ONE;
                end
            end
            ONE: begin
                if (accept_c && xfer_c) begin
                    out_data_d = sel_word_c;
                    sel_err_d  = ~sel_hit_c;
                end else if (accept_c) begin
                    skid_data_d = sel_word_c;
                    skid_err_d  = ~sel_hit_c;
                    state_d     = TWO;
                end else if (xfer_c) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (xfer_c) begin
                    out_data_d  = skid_data_q;
                    sel_err_d   = skid_err_q;
                    skid_data_d = '0;
                    skid_err_d  = 1'b0;
                    state_d     = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != TWO);
    end

    // State and datapath registers; reset discards all buffered beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            out_data_q  <= '0;
            sel_err_q   <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            sel_err_q   <= sel_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;

`ifdef MUX_SEL_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Count transferred out-of-range beats, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 8'h00;
        end else if (xfer_c && sel_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'h01;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed testbench for mux_nto1_pipe (default parameters: 3 x 32-bit inputs,
// DEFAULT_VAL = 0). Define MUX_SEL_ERR_CNT_EN to also exercise err_cnt.
module tb_mux_nto1_pipe;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NUM_IN = 3;
    localparam int unsigned SEL_W  = 2;

    logic                    clk;
    logic                    rst;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;
`ifdef MUX_SEL_ERR_CNT_EN
    logic [7:0]              err_cnt;
`endif

    int total = 0;
    int bad   = 0;

    mux_nto1_pipe #(
        .WIDTH       (WIDTH),
        .NUM_IN      (NUM_IN),
        .SEL_W       (SEL_W),
        .DEFAULT_VAL (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
`ifdef MUX_SEL_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_data   = {32'h100, 32'h10, 32'h1};
        sel       = 2'd0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_in_ready",  32'(in_ready),  32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data",  out_data,       32'h0);
        check("rst_sel_err",   32'(sel_err),   32'h0);
`ifdef MUX_SEL_ERR_CNT_EN
        check("rst_err_cnt",   32'(err_cnt),   32'h0);
`endif
        step();
        step();
        rst = 1'b0;
        check("rel_in_ready_pre", 32'(in_ready), 32'h0);
        step();
        check("rel_in_ready_post", 32'(in_ready), 32'h1);

        // Directed selects at full throughput, then an out-of-range select
        in_valid = 1'b1;
        sel      = 2'd0;
        step();
        check("sel0_data",  out_data,        32'h1);
        check("sel0_valid", 32'(out_valid),  32'h1);
        check("sel0_err",   32'(sel_err),    32'h0);
        sel = 2'd1;
        step();
        check("sel1_data",  out_data,        32'h10);
        check("sel1_err",   32'(sel_err),    32'h0);
        sel = 2'd2;
        step();
        check("sel2_data",  out_data,        32'h100);
        check("sel2_err",   32'(sel_err),    32'h0);
        check("sel2_ready", 32'(in_ready),   32'h1);
        sel = 2'd3;
        step();
        check("oor_data",   out_data,        32'h0);
        check("oor_err",    32'(sel_err),    32'h1);
        check("oor_valid",  32'(out_valid),  32'h1);
        in_valid = 1'b0;
        step();
        check("drain_valid", 32'(out_valid), 32'h0);
`ifdef MUX_SEL_ERR_CNT_EN
        check("oor_err_cnt", 32'(err_cnt),   32'h1);
`endif

        // Unhandshaked changes while empty
        sel     = 2'd1;
        in_data = {32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678};
        step();
        check("nohs_empty_valid", 32'(out_valid), 32'h0);
        check("nohs_empty_data",  out_data,       32'h0);

        // Unhandshaked changes while holding a beat under backpressure
        in_data   = {32'h100, 32'h10, 32'h1};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd1;
        step();
        check("hold_data", out_data, 32'h10);
        in_valid = 1'b0;
        sel      = 2'd2;
        in_data  = {32'hAAAA_AAAA, 32'h5555_5555, 32'h0F0F_0F0F};
        step();
        step();
        check("nohs_hold_data",  out_data,       32'h10);
        check("nohs_hold_valid", 32'(out_valid), 32'h1);
        check("nohs_hold_ready", 32'(in_ready),  32'h1);
        out_ready = 1'b1;
        step();
        check("nohs_drain_valid", 32'(out_valid), 32'h0);

        // Backpressure: two beats fit, the third waits until space frees
        in_data   = {32'h100, 32'h10, 32'h1};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd0;
        step();
        check("bp1_data",  out_data,       32'h1);
        check("bp1_ready", 32'(in_ready),  32'h1);
        sel = 2'd1;
        step();
        check("bp2_data",  out_data,       32'h1);
        check("bp2_ready", 32'(in_ready),  32'h0);
        sel = 2'd2;
        step();
        check("bp3_data",  out_data,       32'h1);
        check("bp3_ready", 32'(in_ready),  32'h0);
        check("bp3_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        #1;
        check("bp_out0_data", out_data, 32'h1);
        step();
        check("bp_out1_data",  out_data,      32'h10);
        check("bp_out1_ready", 32'(in_ready), 32'h1);
        step();
        check("bp_out2_data",  out_data,       32'h100);
        check("bp_out2_valid", 32'(out_valid), 32'h1);
        in_valid = 1'b0;
        step();
        check("bp_drain_valid", 32'(out_valid), 32'h0);

        // Asynchronous reset while in TWO
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd1;
        step();
        sel = 2'd2;
        step();
        check("two_ready", 32'(in_ready), 32'h0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid",   32'(out_valid), 32'h0);
        check("arst_data",    out_data,       32'h0);
        check("arst_ready",   32'(in_ready),  32'h0);
        check("arst_sel_err", 32'(sel_err),   32'h0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_ready", 32'(in_ready),  32'h1);
        check("post_rst_valid", 32'(out_valid), 32'h0);
        out_ready = 1'b1;
        step();
        check("post_rst_stale", 32'(out_valid), 32'h0);
`ifdef MUX_SEL_ERR_CNT_EN
        check("post_rst_err_cnt", 32'(err_cnt), 32'h0);

        // Saturation after 260 out-of-range beats
        in_valid = 1'b1;
        sel      = 2'd3;
        for (int i = 0; i < 260; i++) begin
            step();
        end
        in_valid = 1'b0;
        step();
        check("sat_err_cnt", 32'(err_cnt),   32'hFF);
        check("sat_valid",   32'(out_valid), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_nto1_pipe.md
Name: mux_nto1_pipe

Overview:
- Parametrised N-input, WIDTH-bit selector with a registered output stage and valid/ready handshakes on both sides.
- Successor to the combinational 3-to-1 datapath mux.
- Sits between pipeline stages: ALU operand/forwarding select, writeback select, PC-source select.
- Select and data are captured only on an accepted handshake; a 2-entry skid buffer gives full throughput under backpressure.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 3, number of data inputs (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.
- DEFAULT_VAL, 32'h0, value driven for an out-of-range select (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  packed inputs; input i = in_data[i*WIDTH +: WIDTH].
- sel  input  SEL_W  input index, sampled with in_data.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat.
- out_data  output  WIDTH  selected, registered data.
- out_valid  output  1  out_data/sel_err valid.
- out_ready  input  1  downstream accepts beat.
- sel_err  output  1  current output beat came from an out-of-range select.
- err_cnt  output  8  saturating error count (present only with MUX_SEL_ERR_CNT_EN).

Behaviour:
- Clocking: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, sel_err=0, skid entry empty/zero, err_cnt=0. in_ready=0 while rst=1 and 1 on the first clk edge after release.
- Handshakes:
  - Accept on in_valid & in_ready at a rising edge.
  - Output transfer on out_valid & out_ready.
  - out_data and sel_err are stable while out_valid=1 & out_ready=0.
- Selection:
  - Selected word = input[sel] when sel < NUM_IN.
  - Otherwise the word is DEFAULT_VAL and sel_err=1 for that beat; never X.
  - Computed combinationally from the accepted inputs, then registered.
  - Changes on sel/in_data without a handshake have no effect.
- Latency: 1 cycle. A beat accepted at edge k is on out_data with out_valid=1 after edge k.
- in_ready = !skid_full (from register state, no combinational path from out_ready).
- States:
  - EMPTY: out_valid=0.
    - Accept -> ONE.
  - ONE: output register valid, skid empty.
    - Accept & transfer -> ONE (new beat replaces output).
    - Accept & no transfer -> TWO (new beat into skid).
    - Transfer only -> EMPTY.
  - TWO: output register and skid valid; in_ready=0.
    - Transfer -> ONE (skid moves to output register, skid cleared).
- Throughput: 1 beat/cycle when out_ready is held high. Beats are delivered in order, none dropped or duplicated.
- Reset mid-operation: all buffered beats are discarded and outputs return to reset values immediately (asynchronously).
- NUM_IN not a power of two: unused select codes are out-of-range per the rules above.

Optional Feature:
- Macro: MUX_SEL_ERR_CNT_EN.
- Defined:
  - err_cnt port exists.
  - Increments by 1 on each output transfer whose sel_err=1.
  - Saturates at 8'hFF; reset to 0.
- Undefined: no err_cnt port, no counter logic. All other behaviour is identical.

Test Plan:
- Directed selects:
  - Stimulus: NUM_IN=3, inputs 32'h1/32'h10/32'h100, out_ready=1; sel=0,1,2 on consecutive cycles.
  - Response: out_data = 32'h1, 32'h10, 32'h100 one cycle after each accept; sel_err=0.
- Out-of-range select:
  - Stimulus: sel=3 with DEFAULT_VAL=0.
  - Response: out_data=0, sel_err=1, no X; with macro, err_cnt increments to 1 on transfer.
- Backpressure:
  - Stimulus: out_ready=0 with 3 beats offered (sel=0,1,2).
  - Response: first two accepted, in_ready=0 on the third; out_data holds 32'h1. Raising out_ready yields 32'h1, 32'h10, 32'h100 in order.
- Unhandshaked change:
  - Stimulus: change sel/in_data while in_valid=0.
  - Response: out_data and out_valid are unchanged.
- Async reset:
  - Stimulus: assert rst mid-cycle while in state TWO.
  - Response: out_valid=0, out_data=0 and in_ready=0 immediately, before the next edge. After release, in_ready=1 and no stale beats appear.
- Saturation (macro only):
  - Stimulus: 260 out-of-range beats.
  - Response: err_cnt=8'hFF.
